seg_readback: RTL and testbench



---
 rtl/seg_readback.sv | 115 +++++++++++
 tb/tb_seg_readback.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_readback.sv
`default_nettype none
// ============================================================================
// Module   : seg_readback
// Purpose  : Recovers the hex byte shown on a two-digit active-low 7-seg word,
//            committing only after STABLE_CYCLES identical valid samples.
// Revision : 1.0
// ============================================================================
module seg_readback #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [13:0] seg,
  output logic [7:0]  value,
  output logic        out_valid,
  output logic        blank,
  output logic        err
);

  localparam logic [3:0]  c_stable     = 4'(STABLE_CYCLES);
  localparam logic [13:0] c_blank_word = 14'h3FFF;

  logic [13:0] r_cand;
  logic [3:0]  r_cnt;
  logic [7:0]  r_value;
  logic        r_out_valid;
  logic        r_blank;
  logic        r_err;

  logic        w_match;
  logic        w_commit;
  logic [3:0]  w_cnt_next;
  logic        w_hi_ok;
  logic        w_lo_ok;
  logic [3:0]  w_hi_nib;
  logic [3:0]  w_lo_nib;

  // Returns {legal, nibble}; blank and illegal codes both report legal=0.
  function automatic logic [4:0] f_decode(input logic [6:0] code);
    case (code)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h10:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h46:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    {w_hi_ok, w_hi_nib} = f_decode(seg[13:7]);
    {w_lo_ok, w_lo_nib} = f_decode(seg[6:0]);
  end

  // A restarted run counts as starting from zero, so with a threshold of one
  // every changed word commits even though the old count was already one.
  always_comb begin
    w_match    = (r_cnt != 4'd0) && (seg == r_cand);
    w_cnt_next = 4'd1;
    if (w_match) begin
      w_cnt_next = (r_cnt >= c_stable) ? c_stable : r_cnt + 4'd1;
    end
    w_commit = in_valid && (w_cnt_next == c_stable) &&
               (!w_match || (r_cnt < c_stable));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand      <= c_blank_word;
      r_cnt       <= 4'd0;
      r_value     <= 8'h00;
      r_out_valid <= 1'b0;
      r_blank     <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= w_commit;
      if (in_valid) begin
        r_cand <= seg;
        r_cnt  <= w_cnt_next;
      end
      if (w_commit) begin
        if (w_hi_ok && w_lo_ok) begin
          r_value <= {w_hi_nib, w_lo_nib};
          r_blank <= 1'b0;
          r_err   <= 1'b0;
        end else if (seg == c_blank_word) begin
          r_blank <= 1'b1;
          r_err   <= 1'b0;
        end else begin
          r_blank <= 1'b0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign value     = r_value;
  assign out_valid = r_out_valid;
  assign blank     = r_blank;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_readback
// Purpose  : Self-checking bench for seg_readback (thresholds 4 and 1).
// Revision : 1.0
// ============================================================================
module tb_seg_readback;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [13:0] seg;
  logic [7:0]  dv [2];
  logic        dov [2];
  logic        dbl [2];
  logic        der [2];

  seg_readback #(.STABLE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .seg(seg),
    .value(dv[0]), .out_valid(dov[0]), .blank(dbl[0]), .err(der[0])
  );

  seg_readback #(.STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .seg(seg),
    .value(dv[1]), .out_valid(dov[1]), .blank(dbl[1]), .err(der[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] codes [16];
  int         thr [2];

  // Reference model: unbounded run length, commit exactly when it reaches the threshold.
  int          m_run [2];
  logic [13:0] m_cand [2];
  logic [7:0]  m_val [2];
  logic        m_ov [2];
  logic        m_blk [2];
  logic        m_err [2];

  typedef struct {
    logic        iv;
    logic [13:0] seg;
    logic [7:0]  v;
    logic        ov;
    logic        b;
    logic        e;
  } vec_t;

  vec_t       vecs [$];
  logic [7:0] ev;
  logic       eb;
  logic       ee;

  function automatic int dec(input logic [6:0] c);
    if (c == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_cand[k] = 14'h3FFF; m_val[k] = 8'h00;
      m_ov[k] = 1'b0; m_blk[k] = 1'b1; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic iv, input logic [13:0] s);
    int h;
    int l;
    for (int k = 0; k < 2; k++) begin
      m_ov[k] = 1'b0;
      if (iv) begin
        if (m_run[k] != 0 && s == m_cand[k]) m_run[k] = m_run[k] + 1;
        else m_run[k] = 1;
        m_cand[k] = s;
        if (m_run[k] == thr[k]) begin
          m_ov[k] = 1'b1;
          h = dec(s[13:7]);
          l = dec(s[6:0]);
          if (h >= 0 && h < 16 && l >= 0 && l < 16) begin
            m_val[k] = {h[3:0], l[3:0]}; m_blk[k] = 1'b0; m_err[k] = 1'b0;
          end else if (h == 16 && l == 16) begin
            m_blk[k] = 1'b1; m_err[k] = 1'b0;
          end else begin
            m_blk[k] = 1'b0; m_err[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s dut%0d.value", tag, k), dv[k], m_val[k]);
      chk($sformatf("%s dut%0d.out_valid", tag, k), {7'd0, dov[k]}, {7'd0, m_ov[k]});
      chk($sformatf("%s dut%0d.blank", tag, k), {7'd0, dbl[k]}, {7'd0, m_blk[k]});
      chk($sformatf("%s dut%0d.err", tag, k), {7'd0, der[k]}, {7'd0, m_err[k]});
    end
  endtask

  task automatic check_const(input string tag, input int k, input logic [7:0] v,
                             input logic ov, input logic b, input logic e);
    chk($sformatf("%s dut%0d.value", tag, k), dv[k], v);
    chk($sformatf("%s dut%0d.out_valid", tag, k), {7'd0, dov[k]}, {7'd0, ov});
    chk($sformatf("%s dut%0d.blank", tag, k), {7'd0, dbl[k]}, {7'd0, b});
    chk($sformatf("%s dut%0d.err", tag, k), {7'd0, der[k]}, {7'd0, e});
  endtask

  task automatic step(input logic iv, input logic [13:0] s, input string tag);
    in_valid = iv;
    seg      = s;
    @(posedge clk);
    model_edge(iv, s);
    #1;
    check_all(tag);
  endtask

  // Asynchronous pulse placed mid-cycle, checked while reset is still high.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #2 reset = 1'b0;
  endtask

  task automatic add(input logic iv, input logic [13:0] s, input logic ov);
    vec_t r;
    r.iv = iv; r.seg = s; r.v = ev; r.ov = ov; r.b = eb; r.e = ee;
    vecs.push_back(r);
  endtask

  task automatic run4(input logic [13:0] s, input logic [7:0] nv, input logic nb, input logic ne);
    for (int i = 0; i < 3; i++) add(1'b1, s, 1'b0);
    ev = nv; eb = nb; ee = ne;
    add(1'b1, s, 1'b1);
  endtask

  function automatic logic [6:0] rnd_digit();
    int r;
    r = int'($urandom_range(7, 0));
    if (r == 0) return 7'h7F;
    if (r == 1) return 7'($urandom);
    return codes[$urandom_range(15, 0)];
  endfunction

  initial begin
    logic [13:0] pool [6];
    logic [13:0] cur;

    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    thr = '{4, 1};

    reset    = 1'b1;
    in_valid = 1'b0;
    seg      = 14'h0000;
    model_reset();
    #12;
    check_const("reset", 0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_const("reset", 1, 8'h00, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;

    // Hand-derived expectations for the threshold-4 instance.
    ev = 8'h00; eb = 1'b1; ee = 1'b0;
    run4(14'h3CA4, 8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b1, 14'h3CA4, 1'b0);
    add(1'b1, 14'h3FFF, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 14'h3CA4, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 14'h0000, 1'b0);
    ev = 8'h88;
    add(1'b1, 14'h0000, 1'b1);
    add(1'b1, 14'h0000, 1'b0);
    add(1'b1, 14'h2321, 1'b0);
    add(1'b0, 14'h0000, 1'b0);
    add(1'b1, 14'h2321, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 14'h1111, 1'b0);
    add(1'b1, 14'h2321, 1'b0);
    ev = 8'hCD;
    add(1'b1, 14'h2321, 1'b1);
    add(1'b0, 14'h0000, 1'b0);
    run4(14'h2003, 8'h0B, 1'b0, 1'b0);
    run4(14'h3FFF, 8'h0B, 1'b1, 1'b0);
    run4(14'h3FF9, 8'h0B, 1'b0, 1'b1);
    run4(14'h2AC0, 8'h0B, 1'b0, 1'b1);
    run4(14'h1230, 8'h23, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].iv, vecs[i].seg, $sformatf("model vec%0d", i));
      check_const($sformatf("vec%0d", i), 0, vecs[i].v, vecs[i].ov, vecs[i].b, vecs[i].e);
    end

    // Reset mid-run, then a single sample edge.
    for (int i = 0; i < 3; i++) step(1'b1, 14'h3CA4, "midrun");
    pulse_reset();
    check_const("rst_mid", 0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_const("rst_mid", 1, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 14'h3CA4, "after_rst");
    check_const("after_rst", 0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_const("after_rst", 1, 8'h12, 1'b1, 1'b0, 1'b0);
    pulse_reset();
    check_const("rst_pending", 1, 8'h00, 1'b0, 1'b1, 1'b0);

    // Randomized runs against the model.
    for (int i = 0; i < 6; i++) pool[i] = {rnd_digit(), rnd_digit()};
    pool[5] = 14'h3FFF;
    cur = pool[0];
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3, 0) == 0) cur = pool[$urandom_range(5, 0)];
      step(($urandom_range(3, 0) != 0), cur, "rand");
      if ($urandom_range(59, 0) == 0) pulse_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
